// File: rtl/distram_fifo_pro.sv
// distram_fifo_pro: parameterised distributed-RAM FIFO with true full
// detection, sticky overflow/underflow, almost flags, synchronous flush
// and optional first-word-fall-through output stage.
module distram_fifo_pro #(
    parameter int FIFO_WIDTH                 = 64,
    parameter int FIFO_DEPTH_BITS            = 5,
    parameter int FIFO_ALMOSTFULL_THRESHOLD  = 2**FIFO_DEPTH_BITS - 6,
    parameter int FIFO_ALMOSTEMPTY_THRESHOLD = 2,
    parameter int FWFT                       = 0
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       clr,
    input  logic                       we,
    input  logic [FIFO_WIDTH-1:0]      din,
    output logic                       full,
    output logic                       almostfull,
    output logic                       overflow,
    input  logic                       re,
    output logic                       valid,
    output logic [FIFO_WIDTH-1:0]      dout,
    output logic                       empty,
    output logic                       almostempty,
    output logic                       underflow,
    output logic [FIFO_DEPTH_BITS:0]   count
);

    localparam int               CAP     = 2**FIFO_DEPTH_BITS;
    localparam int               PW      = FIFO_DEPTH_BITS + 1;
    localparam logic [PW-1:0]    CAP_CNT = PW'(CAP);

    // Storage is left unreset so it maps onto distributed RAM.
    logic [FIFO_WIDTH-1:0] r_mem [CAP];

    logic [PW-1:0]         r_wptr;
    logic [PW-1:0]         r_rptr;
    logic [PW-1:0]         r_count;
    logic [FIFO_WIDTH-1:0] r_dout;
    logic                  r_valid;
    logic                  r_ovf;
    logic                  r_udf;

    logic w_ram_ne;   // RAM (not counting output register) holds a word
    logic w_full;
    logic w_empty;
    logic w_wr;       // accepted write
    logic w_rd;       // accepted read (standard) / pop (FWFT)
    logic w_rd_ok;    // a readable word exists this cycle
    logic w_load;     // output register takes the RAM head word

    // Accept/load decode; FWFT moves the RAM head into the output register
    // whenever that register is free or being popped.
    always_comb begin
        w_ram_ne = (r_wptr != r_rptr);
        w_full   = (r_count == CAP_CNT);
        w_wr     = we & ~w_full;
        w_rd_ok  = 1'b0;
        w_rd     = 1'b0;
        w_load   = 1'b0;
        w_empty  = 1'b1;
        if (FWFT != 0) begin
            w_rd_ok = r_valid;
            w_rd    = re & r_valid;
            w_load  = (~r_valid | w_rd) & w_ram_ne;
            w_empty = ~r_valid;
        end else begin
            w_rd_ok = w_ram_ne;
            w_rd    = re & w_ram_ne;
            w_load  = w_rd;
            w_empty = ~w_ram_ne;
        end
    end

    // RAM write port; flush suppresses the write so a cleared FIFO stays empty.
    always_ff @(posedge clk) begin
        if (w_wr && !clr) begin
            r_mem[r_wptr[FIFO_DEPTH_BITS-1:0]] <= din;
        end
    end

    // Pointers, count, output register and sticky error flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_dout  <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else if (clr) begin
            // dout intentionally keeps its last value across a flush
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_valid <= 1'b0;
            r_ovf   <= 1'b0;
            r_udf   <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_load) begin
                r_rptr <= r_rptr + PW'(1);
                r_dout <= r_mem[r_rptr[FIFO_DEPTH_BITS-1:0]];
            end
            if (FWFT != 0) begin
                r_valid <= w_load | (r_valid & ~w_rd);
            end else begin
                r_valid <= w_rd;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + PW'(1);
                2'b01:   r_count <= r_count - PW'(1);
                default: r_count <= r_count;
            endcase
            if (we && w_full) begin
                r_ovf <= 1'b1;
            end
            if (re && !w_rd_ok) begin
                r_udf <= 1'b1;
            end
        end
    end

    assign full        = w_full;
    assign almostfull  = (int'(r_count) >= FIFO_ALMOSTFULL_THRESHOLD);
    assign almostempty = (int'(r_count) <= FIFO_ALMOSTEMPTY_THRESHOLD);
    assign empty       = w_empty;
    assign overflow    = r_ovf;
    assign underflow   = r_udf;
    assign valid       = r_valid;
    assign dout        = r_dout;
    assign count       = r_count;

endmodule

// File: tb/tb_distram_fifo_pro.sv
// Bench for distram_fifo_pro: one standard-mode and one FWFT instance share
// the same stimulus and are each compared every cycle against a queue model.
module tb_distram_fifo_pro;

    localparam int W   = 32;
    localparam int DB  = 5;
    localparam int CAP = 32;
    localparam int AF  = 26;
    localparam int AE  = 2;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b1;
    logic         clr     = 1'b0;
    logic         we      = 1'b0;
    logic         re      = 1'b0;
    logic [W-1:0] din     = '0;

    logic         s_full, s_af, s_ovf, s_valid, s_empty, s_ae, s_udf;
    logic [W-1:0] s_dout;
    logic [DB:0]  s_count;
    logic         f_full, f_af, f_ovf, f_valid, f_empty, f_ae, f_udf;
    logic [W-1:0] f_dout;
    logic [DB:0]  f_count;

    distram_fifo_pro #(.FIFO_WIDTH(W), .FIFO_DEPTH_BITS(DB), .FWFT(0)) u_std (
        .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .din(din),
        .full(s_full), .almostfull(s_af), .overflow(s_ovf), .re(re),
        .valid(s_valid), .dout(s_dout), .empty(s_empty),
        .almostempty(s_ae), .underflow(s_udf), .count(s_count));

    distram_fifo_pro #(.FIFO_WIDTH(W), .FIFO_DEPTH_BITS(DB), .FWFT(1)) u_fwft (
        .clk(clk), .reset_n(reset_n), .clr(clr), .we(we), .din(din),
        .full(f_full), .almostfull(f_af), .overflow(f_ovf), .re(re),
        .valid(f_valid), .dout(f_dout), .empty(f_empty),
        .almostempty(f_ae), .underflow(f_udf), .count(f_count));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference state: queues hold every word the FIFO owns.
    logic [W-1:0] sq[$];
    logic [W-1:0] fq[$];
    bit           s_v, s_ov, s_un, f_v, f_ov, f_un;
    logic [W-1:0] s_d, f_d;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        sq.delete(); fq.delete();
        s_v = 0; s_ov = 0; s_un = 0; s_d = '0;
        f_v = 0; f_ov = 0; f_un = 0; f_d = '0;
    endtask

    // Advance both models by one clock edge using the inputs now driven.
    task automatic model_step();
        int n;
        bit rd, wr, pop;
        if (clr) begin
            sq.delete(); fq.delete();
            s_v = 0; s_ov = 0; s_un = 0;
            f_v = 0; f_ov = 0; f_un = 0;
        end else begin
            n  = sq.size();
            rd = re && (n > 0);
            wr = we && (n < CAP);
            if (re && !rd) s_un = 1;
            if (we && !wr) s_ov = 1;
            if (rd) s_d = sq.pop_front();
            s_v = rd;
            if (wr) sq.push_back(din);

            n   = fq.size();
            pop = re && f_v;
            wr  = we && (n < CAP);
            if (re && !f_v) f_un = 1;
            if (we && !wr) f_ov = 1;
            if (pop) void'(fq.pop_front());
            // presented word is whatever head remains before this edge's write
            f_v = (fq.size() > 0);
            if (f_v) f_d = fq[0];
            if (wr) fq.push_back(din);
        end
    endtask

    task automatic check_all();
        chk("s_count", s_count, sq.size());
        chk("s_full", s_full, sq.size() == CAP);
        chk("s_almostfull", s_af, sq.size() >= AF);
        chk("s_empty", s_empty, sq.size() == 0);
        chk("s_almostempty", s_ae, sq.size() <= AE);
        chk("s_valid", s_valid, s_v);
        chk("s_dout", s_dout, s_d);
        chk("s_overflow", s_ovf, s_ov);
        chk("s_underflow", s_udf, s_un);
        chk("f_count", f_count, fq.size());
        chk("f_full", f_full, fq.size() == CAP);
        chk("f_almostfull", f_af, fq.size() >= AF);
        chk("f_empty", f_empty, !f_v);
        chk("f_almostempty", f_ae, fq.size() <= AE);
        chk("f_valid", f_valid, f_v);
        chk("f_dout", f_dout, f_d);
        chk("f_overflow", f_ovf, f_ov);
        chk("f_underflow", f_udf, f_un);
    endtask

    // Drive one cycle of inputs (from the falling edge), then check.
    task automatic cyc(input bit w, input bit r, input bit c, input logic [W-1:0] d);
        we = w; re = r; clr = c; din = d;
        model_step();
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    initial begin
        // async reset before any clock edge
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        cyc(0, 0, 0, '0);

        // standard-order A,B,C then three reads
        cyc(1, 0, 0, 32'hA);
        cyc(1, 0, 0, 32'hB);
        cyc(1, 0, 0, 32'hC);
        cyc(0, 1, 0, '0);
        chk("abc_first", s_dout, 32'hA);
        cyc(0, 1, 0, '0);
        chk("abc_second", s_dout, 32'hB);
        cyc(0, 1, 0, '0);
        chk("abc_third", s_dout, 32'hC);
        chk("abc_empty", s_empty, 1'b1);

        // fill past capacity, then full + simultaneous we/re
        cyc(0, 0, 1, '0);
        for (int i = 0; i < CAP + 1; i++) cyc(1, 0, 0, $urandom);
        chk("fill_count", s_count, 6'd32);
        chk("fill_ovf", s_ovf, 1'b1);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, '0);
        cyc(1, 1, 0, $urandom);
        cyc(0, 0, 1, '0);
        chk("clr_ovf", f_ovf, 1'b0);

        // FWFT single word latency
        cyc(1, 0, 0, 32'h55);
        chk("fwft_edge1_valid", f_valid, 1'b0);
        cyc(0, 0, 0, '0);
        chk("fwft_edge2_valid", f_valid, 1'b1);
        chk("fwft_edge2_dout", f_dout, 32'h55);
        cyc(0, 1, 0, '0);
        chk("fwft_pop_empty", f_empty, 1'b1);
        chk("fwft_pop_count", f_count, 6'd0);

        // wrap-around at steady count 4
        cyc(0, 0, 1, '0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, $urandom);
        for (int i = 0; i < 100; i++) begin
            cyc(1, 1, 0, $urandom);
            chk("wrap_count", s_count, 6'd4);
        end

        // underflow, then first write alongside a read on empty
        cyc(0, 0, 1, '0);
        cyc(0, 1, 0, '0);
        chk("udf_set", s_udf, 1'b1);
        cyc(1, 1, 0, 32'h77);
        chk("udf_write_count", s_count, 6'd1);

        // asynchronous reset mid-burst
        cyc(0, 0, 1, '0);
        for (int i = 0; i < 11; i++) cyc(1, 0, 0, $urandom);
        cyc(0, 1, 0, '0);
        chk("burst_count", s_count, 6'd10);
        chk("burst_valid", s_valid, 1'b1);
        #2 reset_n = 1'b0;
        #1 model_reset();
        check_all();
        @(negedge clk);
        reset_n = 1'b1;

        // flush at count 10
        for (int i = 0; i < 10; i++) cyc(1, 0, 0, $urandom);
        cyc(0, 0, 1, '0);
        chk("clr_empty", s_empty, 1'b1);

        // randomized traffic with phases biased toward full and toward empty
        for (int p = 0; p < 6; p++) begin
            int wp;
            wp = (p % 2 == 0) ? 80 : 25;
            for (int i = 0; i < 120; i++) begin
                cyc($urandom_range(0, 99) < wp, $urandom_range(0, 99) < 100 - wp,
                    $urandom_range(0, 99) < 2, $urandom);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
